vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Raster timing generator, directly upstream of the on-screen text generator. Divides clk_i down to a pixel tick and runs horizontal/vertical counters. Produces pix_x/pix_y coordinates (consumed by the text/font stage), hsync/vsync for the monitor, and video_on for blanking. Default timing is 640x480@60 Hz from a 50 MHz clk_i.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, clk_i cycles per pixel; must be 1 or greater

Ports:
clk_i  in  1  system clock; all state changes on its rising edge
rst_i  in  1  asynchronous, active-high reset
p_tick  out  1  pixel-enable strobe, one clk_i cycle wide
pix_x  out  10  current column, 0..H_TOTAL-1
pix_y  out  10  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, active-low by default
vsync  out  1  vertical sync, active-low by default
video_on  out  1  high when (pix_x, pix_y) lies inside the visible area
frame_start  out  1  one-cycle pulse when the raster returns to (0,0)

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525. Both totals must be 1024 or less, because the counters are 10 bits wide.
- Reset (asynchronous, takes effect immediately on rst_i rising):
  - divider = 0; pix_x = 0; pix_y = 0.
  - p_tick = 0; frame_start = 0; video_on = 0.
  - hsync = 1 and vsync = 1, i.e. both inactive.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - p_tick = 1 in the clk_i cycle where divider == CLK_DIV-1.
  - If CLK_DIV == 1, p_tick = 1 in every cycle once reset is released.
- Counters advance only on a clk_i edge where p_tick = 1:
  - pix_x increments; at H_TOTAL-1 it wraps to 0.
  - pix_y increments only when pix_x wraps; at V_TOTAL-1 it wraps to 0.
  - No other count values are ever produced.
- Registered outputs:
  - hsync, vsync, video_on and frame_start are registers.
  - They are computed from the next-state counter values, so in every cycle after reset release they describe the pix_x/pix_y currently on the outputs.
  - There is zero cycle skew between the coordinates and the sync/blank outputs.
- hsync = 0 iff H_DISPLAY+H_FRONT <= pix_x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
- vsync = 0 iff V_DISPLAY+V_FRONT <= pix_y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- video_on = (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY).
- frame_start:
  - = 1 for exactly one clk_i cycle: the first cycle in which pix_x/pix_y read (0,0) after the wrap from (799,524).
  - Not asserted on reset release.
- After reset release, the first cycle presents (0,0) with video_on = 1, hsync = 1, vsync = 1.
- Reset asserted mid-frame: outputs return to reset values in the same cycle. There is no partial-line completion.
- Downstream stages that register their pixel output must delay hsync/vsync by the same number of cycles. That delay is not done in this block.

Optional Feature:
VGA_SYNC_POS_POL_EN
- Defined: hsync/vsync are active-high. Reset value of both is 0; both are 1 inside the sync windows above.
- Undefined: active-low, as described in Behaviour.
- No other behaviour, including timing and video_on, changes.

Test Plan:
- Reset mid-frame: run to pix=(300,200), pulse rst_i between clock edges -> pix=(0,0), hsync=vsync=1, video_on=0, p_tick=0 before the next edge; first post-release cycle video_on=1.
- Divider, CLK_DIV=2: p_tick alternates 0,1,0,1; pix_x steps 0->1->2 every 2 clk_i cycles; no increment on p_tick=0 cycles.
- Horizontal timing: hsync low exactly 96 p_ticks, first low at pix_x=656, last at 751; line period 800 p_ticks; video_on high for pix_x 0..639 on line 0.
- Vertical/frame timing:
  - vsync low only on lines 490 and 491, i.e. 1600 p_ticks.
  - video_on high for 307200 p_ticks per frame.
  - frame_start pulses once per 420000 p_ticks (840000 clk_i cycles).
- Wrap boundary: at (799,524) with p_tick=1 -> next cycle (0,0), frame_start=1 for one cycle; at (799,100) -> (0,101), frame_start=0.
- Macro build with VGA_SYNC_POS_POL_EN: reset -> hsync=vsync=0; hsync=1 for pix_x 656..751; vsync=1 for lines 490..491; all counter and video_on checks above unchanged.

Source files
------------

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : Raster timing generator for the on-screen text path.
//               Divides clk_i into a single-cycle pixel strobe and runs the
//               horizontal/vertical counters. Emits the pixel coordinate,
//               monitor sync pulses and the visible-area flag. All sync and
//               blank outputs are registered and aligned with pix_x/pix_y.
//               Default timing is 640x480@60 Hz from a 50 MHz clk_i.
//
// Ports       : clk_i        in   system clock, rising-edge active
//               rst_i        in   asynchronous active-high reset
//               p_tick       out  pixel-enable strobe, one clk_i cycle wide
//               pix_x        out  current column, 0..H_TOTAL-1
//               pix_y        out  current line,   0..V_TOTAL-1
//               hsync        out  horizontal sync (active-low by default)
//               vsync        out  vertical sync   (active-low by default)
//               video_on     out  high inside the visible area
//               frame_start  out  one-cycle pulse on return to (0,0)
//
// Options     : VGA_SYNC_POS_POL_EN - when defined, hsync/vsync are
//               active-high (idle/reset level 0). Timing is unchanged.
//
// Constraints : CLK_DIV >= 1; H_TOTAL and V_TOTAL must each be <= 1024.
//
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last = 10'(c_h_total - 1);
  localparam logic [9:0] c_v_last = 10'(c_v_total - 1);

  // Window bounds are kept 11 bits wide so a 1024-wide display area does
  // not truncate to zero.
  localparam logic [10:0] c_h_disp     = 11'(H_DISPLAY);
  localparam logic [10:0] c_v_disp     = 11'(V_DISPLAY);
  localparam logic [10:0] c_hs_first   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] c_hs_last    = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] c_vs_first   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] c_vs_last    = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

`ifdef VGA_SYNC_POS_POL_EN
  localparam logic c_sync_act = 1'b1;
`else
  localparam logic c_sync_act = 1'b0;
`endif
  localparam logic c_sync_idle = ~c_sync_act;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic       w_tick_nxt;
  logic       r_tick;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_wrap;
  logic       w_hs_win;
  logic       w_vs_win;
  logic       w_vis;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_frame_start;

  // --------------------------------------------------------------------------
  // Clock divider
  // The strobe is registered from the divider's next value so that it reads
  // 0 while in reset even when CLK_DIV == 1, and equals
  // (divider == CLK_DIV-1) in every cycle afterwards.
  // --------------------------------------------------------------------------
  generate
    if (CLK_DIV == 1) begin : g_div_one
      assign w_tick_nxt = 1'b1;
    end else begin : g_div_n
      localparam int              c_div_w    = $clog2(CLK_DIV);
      localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
      localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

      logic [c_div_w-1:0] r_div;
      logic [c_div_w-1:0] w_div_nxt;

      always_comb begin
        if (r_div == c_div_last) begin
          w_div_nxt = '0;
        end else begin
          w_div_nxt = r_div + c_div_one;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_div <= '0;
        end else begin
          r_div <= w_div_nxt;
        end
      end

      assign w_tick_nxt = (w_div_nxt == c_div_last);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Raster counters: next-state values
  // --------------------------------------------------------------------------
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_tick) begin
      if (r_x == c_h_last) begin
        w_x_nxt = '0;
        if (r_y == c_v_last) begin
          w_y_nxt = '0;
        end else begin
          w_y_nxt = r_y + 10'd1;
        end
      end else begin
        w_x_nxt = r_x + 10'd1;
      end
    end
  end

  assign w_wrap = r_tick && (r_x == c_h_last) && (r_y == c_v_last);

  // Decode from the next coordinate so the registered flags line up with
  // the coordinate registers in the same cycle.
  assign w_hs_win = ({1'b0, w_x_nxt} >= c_hs_first) && ({1'b0, w_x_nxt} <= c_hs_last);
  assign w_vs_win = ({1'b0, w_y_nxt} >= c_vs_first) && ({1'b0, w_y_nxt} <= c_vs_last);
  assign w_vis    = ({1'b0, w_x_nxt} <  c_h_disp)   && ({1'b0, w_y_nxt} <  c_v_disp);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= c_sync_idle;
      r_vsync       <= c_sync_idle;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= w_hs_win ? c_sync_act : c_sync_idle;
      r_vsync       <= w_vs_win ? c_sync_act : c_sync_idle;
      r_video_on    <= w_vis;
      // Only the wrap from the last pixel sets this; reset release never does.
      r_frame_start <= w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign p_tick      = r_tick;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen. Three instances share
//               clk/rst: default 640x480 timing (CLK_DIV=2), a reduced
//               15x11 raster with CLK_DIV=3, and the same reduced raster with
//               CLK_DIV=1, so full-frame behaviour fits a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
  } obs_t;

`ifdef VGA_SYNC_POS_POL_EN
  localparam logic ACT = 1'b1;
`else
  localparam logic ACT = 1'b0;
`endif
  localparam logic IDLE = !ACT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k   = 0;       // clk edges since reset release
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // ---------------- instances ----------------
  logic       d_tick, d_hs, d_vs, d_von, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_hs, s_vs, s_von, s_fs;
  logic [9:0] s_x, s_y;
  logic       o_tick, o_hs, o_vs, o_von, o_fs;
  logic [9:0] o_x, o_y;

  vga_sync_gen u_def (
    .clk_i(clk), .rst_i(rst), .p_tick(d_tick), .pix_x(d_x), .pix_y(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(3)
  ) u_sml (
    .clk_i(clk), .rst_i(rst), .p_tick(s_tick), .pix_x(s_x), .pix_y(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
  ) u_one (
    .clk_i(clk), .rst_i(rst), .p_tick(o_tick), .pix_x(o_x), .pix_y(o_y),
    .hsync(o_hs), .vsync(o_vs), .video_on(o_von), .frame_start(o_fs)
  );

  obs_t ob_def, ob_sml, ob_one;
  assign ob_def = {d_tick, d_x, d_y, d_hs, d_vs, d_von, d_fs};
  assign ob_sml = {s_tick, s_x, s_y, s_hs, s_vs, s_von, s_fs};
  assign ob_one = {o_tick, o_x, o_y, o_hs, o_vs, o_von, o_fs};

  // ---------------- reference model ----------------
  // Pixels elapsed after kk edges: one pixel per CLK_DIV edges, the first
  // strobe arriving after CLK_DIV edges (or after one edge when CLK_DIV=1).
  function automatic int pixcnt(input int d, input int kk);
    if (d == 1) return (kk > 0) ? kk - 1 : 0;
    return kk / d;
  endfunction

  function automatic obs_t model(input int hd, input int hf, input int hs,
                                 input int hb, input int vd, input int vf,
                                 input int vs, input int vb, input int d,
                                 input int kk);
    obs_t e;
    int ht, vt, p, pp, px, py;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    e = {1'b0, 10'd0, 10'd0, IDLE, IDLE, 1'b0, 1'b0};
    if (kk > 0) begin
      p  = pixcnt(d, kk);
      pp = pixcnt(d, kk - 1);
      px = p % ht;
      py = (p / ht) % vt;
      e.tick = ((kk % d) == d - 1);
      e.x    = 10'(px);
      e.y    = 10'(py);
      e.hs   = (px >= hd + hf && px <= hd + hf + hs - 1) ? ACT : IDLE;
      e.vs   = (py >= vd + vf && py <= vd + vf + vs - 1) ? ACT : IDLE;
      e.von  = (px < hd) && (py < vd);
      e.fs   = (p != pp) && ((p % (ht * vt)) == 0);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cmp_%s k=%0d got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b exp tick=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b",
               nm, k, a.tick, a.x, a.y, a.hs, a.vs, a.von, a.fs,
               e.tick, e.x, e.y, e.hs, e.vs, e.von, e.fs);
    end
  endtask

  // Edge counter since release.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) k = 0;
    else     k = k + 1;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    cmp("def", ob_def, model(640, 16, 96, 48, 480, 10, 2, 33, 2, k));
    cmp("sml", ob_sml, model(8, 2, 3, 2, 6, 1, 2, 2, 3, k));
    cmp("one", ob_one, model(8, 2, 3, 2, 6, 1, 2, 2, 1, k));
  end

  // ---------------- statistics monitor ----------------
  logic mon_en = 1'b1;
  int line_ticks = 0, hs_cnt = 0, hs_first = -1, hs_last = -1, von_cnt = 0;
  int s_fs_n = 0, s_k1 = 0, s_k2 = 0, s_ticks = 0, s_vs_cnt = 0, s_von_cnt = 0;
  int o_fs_n = 0, o_k1 = 0, o_k2 = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en && !rst) begin
      if (d_tick && d_y == 10'd0) begin
        line_ticks++;
        if (d_hs == ACT) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
        if (d_von) von_cnt++;
      end
      if (s_fs) begin
        if (s_fs_n == 0) s_k1 = k;
        else if (s_fs_n == 1) s_k2 = k;
        s_fs_n++;
      end
      if (s_fs_n == 1 && s_tick) begin
        s_ticks++;
        if (s_vs == ACT) s_vs_cnt++;
        if (s_von) s_von_cnt++;
      end
      if (o_fs) begin
        if (o_fs_n == 0) o_k1 = k;
        else if (o_fs_n == 1) o_k2 = k;
        o_fs_n++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x",     d_x,    0);
    chk("rst_y",     d_y,    0);
    chk("rst_hsync", d_hs,   IDLE);
    chk("rst_vsync", d_vs,   IDLE);
    chk("rst_video", d_von,  0);
    chk("rst_tick",  d_tick, 0);
    chk("rst_fs",    d_fs,   0);
    chk("rst_tick_div1", o_tick, 0);

    #2 rst = 1'b0;

    // Divider behaviour on the default instance: strobe 1,0,1,0; x 0,1,1,2.
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("tick_e%0d", i), d_tick, (i % 2));
      chk($sformatf("x_e%0d", i),    d_x,    (i / 2));
    end
    chk("one_tick_steady", o_tick, 1);

    for (int i = 0; i < 6000 && !(d_x == 10'd300 && d_y == 10'd2); i++) @(negedge clk);
    chk("reach_300_2", (d_x == 10'd300 && d_y == 10'd2), 1);

    chk("line0_ticks",   line_ticks, 800);
    chk("hs_low_ticks",  hs_cnt,     96);
    chk("hs_first_x",    hs_first,   656);
    chk("hs_last_x",     hs_last,    751);
    chk("line0_video",   von_cnt,    640);
    chk("sml_fs_period", s_k2 - s_k1, 495);
    chk("sml_frame_ticks", s_ticks,  165);
    chk("sml_vs_ticks",  s_vs_cnt,   30);
    chk("sml_video_ticks", s_von_cnt, 48);
    chk("one_fs_period", o_k2 - o_k1, 165);
    mon_en = 1'b0;

    // Reset pulse between edges, mid-frame.
    #1 rst = 1'b1;
    #1;
    chk("mid_x",     d_x,    0);
    chk("mid_y",     d_y,    0);
    chk("mid_hsync", d_hs,   IDLE);
    chk("mid_vsync", d_vs,   IDLE);
    chk("mid_video", d_von,  0);
    chk("mid_tick",  d_tick, 0);
    chk("mid_sml_x", s_x,    0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_video", d_von, 1);
    chk("post_x",     d_x,   0);
    chk("post_hsync", d_hs,  IDLE);

    // Frame wrap on the reduced raster, CLK_DIV=3.
    for (int i = 0; i < 1200 && !(s_x == 10'd14 && s_y == 10'd10 && s_tick); i++) @(negedge clk);
    chk("sml_reach_wrap", (s_x == 10'd14 && s_y == 10'd10 && s_tick), 1);
    @(negedge clk);
    chk("wrap_x",  s_x,  0);
    chk("wrap_y",  s_y,  0);
    chk("wrap_fs", s_fs, 1);
    @(negedge clk);
    chk("wrap_fs_once", s_fs, 0);

    // Line wrap without frame wrap.
    for (int i = 0; i < 1200 && !(s_x == 10'd14 && s_y == 10'd3 && s_tick); i++) @(negedge clk);
    chk("sml_reach_line", (s_x == 10'd14 && s_y == 10'd3 && s_tick), 1);
    @(negedge clk);
    chk("line_x",  s_x,  0);
    chk("line_y",  s_y,  4);
    chk("line_fs", s_fs, 0);

    // Frame wrap with CLK_DIV=1.
    for (int i = 0; i < 400 && !(o_x == 10'd14 && o_y == 10'd10 && o_tick); i++) @(negedge clk);
    chk("one_reach_wrap", (o_x == 10'd14 && o_y == 10'd10 && o_tick), 1);
    @(negedge clk);
    chk("one_wrap_xy", {o_x, o_y}, 0);
    chk("one_wrap_fs", o_fs, 1);
    @(negedge clk);
    chk("one_next_x",  o_x,  1);
    chk("one_next_fs", o_fs, 0);

    repeat (50) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
